word_decompressor_stream: RTL



---
 rtl/word_decompressor_stream.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/word_decompressor_stream.sv
// word_decompressor_stream
// Sequential token decoder for the word decompressing path. One compressed
// token (code, backup code, index, payload) is accepted per handshake. It is
// decoded against a FIFO dictionary that the block maintains itself, the
// dictionary is updated, and the decoded word leaves through a registered
// valid/ready output stage with one cycle of latency.
//
// Optional feature macro: WORD_DECOMP_FLUSH_EN
//   When defined, the block gains an i_flush input. i_flush synchronously
//   clears the dictionary, the write pointer and the fill count. A token
//   accepted in the same cycle is still decoded against the old dictionary,
//   but its push is dropped. The output stage is not affected by a flush.

module word_decompressor_stream #(
  parameter  int WIDTH = 32,
  parameter  int WORD  = 16,
  parameter  int CODES = 2,
  localparam int IW    = $clog2(WORD),
  localparam int FW    = IW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
`ifdef WORD_DECOMP_FLUSH_EN
  input  logic             i_flush,
`endif
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [CODES-1:0] i_codes,
  input  logic [CODES-1:0] i_codes_bak,
  input  logic [IW-1:0]    i_idx,
  input  logic [WIDTH-1:0] i_word,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_word,
  output logic             o_err,
  output logic [FW-1:0]    o_fill
);

  localparam int H = WIDTH / 2;

  localparam logic [CODES-1:0] CODE_ZERO = CODES'(0);
  localparam logic [CODES-1:0] CODE_LIT  = CODES'(1);
  localparam logic [CODES-1:0] CODE_DICT = CODES'(2);
  localparam logic [CODES-1:0] CODE_EXT  = CODES'(3);

  localparam logic [FW-1:0] FILL_MAX = FW'(WORD);

  logic [WIDTH-1:0] dict [WORD];
  logic [IW-1:0]    wp;

  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] dec_word;
  logic             dec_push;
  logic             dec_ref;
  logic             dec_err;
  logic             accept;
  logic             push_en;
  logic             flush;

`ifdef WORD_DECOMP_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  // The output register can take a new word when it is empty or draining.
  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready;

  // The dictionary is read before this cycle's push, so an index equal to
  // wp returns the old contents (read-before-write).
  assign rd_word = dict[i_idx];

  // Decode the incoming token and decide whether it is pushed and whether
  // it references the dictionary.
  always_comb begin
    dec_word = '0;
    dec_push = 1'b0;
    dec_ref  = 1'b0;
    case (i_codes)
      CODE_ZERO: begin
        dec_word = '0;
      end
      CODE_LIT: begin
        dec_word = i_word;
        dec_push = 1'b1;
      end
      CODE_DICT: begin
        dec_word = rd_word;
        dec_ref  = 1'b1;
      end
      CODE_EXT: begin
        case (i_codes_bak)
          CODE_ZERO: begin
            dec_word = {{(WIDTH-H){1'b0}}, i_word[H-1:0]};
            dec_push = 1'b1;
          end
          CODE_LIT: begin
            dec_word = {{(WIDTH-8){1'b0}}, i_word[7:0]};
          end
          CODE_DICT: begin
            dec_word = {rd_word[WIDTH-1:8], i_word[7:0]};
            dec_push = 1'b1;
            dec_ref  = 1'b1;
          end
          CODE_EXT: begin
            dec_word = i_word;
            dec_push = 1'b1;
          end
          default: begin
            dec_word = '0;
          end
        endcase
      end
      default: begin
        dec_word = '0;
      end
    endcase
  end

  // A dictionary reference is an error when it points past the filled
  // region. The decode above still returns whatever is stored there.
  assign dec_err = dec_ref && ({1'b0, i_idx} >= o_fill);

  // A push happens only for accepted pushing tokens, and a flush in the
  // same cycle discards it.
  assign push_en = accept && dec_push && !flush;

  // Dictionary storage, write pointer and fill count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < WORD; i++) begin
        dict[i] <= '0;
      end
      wp     <= '0;
      o_fill <= '0;
    end else if (flush) begin
      for (int i = 0; i < WORD; i++) begin
        dict[i] <= '0;
      end
      wp     <= '0;
      o_fill <= '0;
    end else if (push_en) begin
      dict[wp] <= dec_word;
      wp       <= wp + IW'(1);
      if (o_fill != FILL_MAX) begin
        o_fill <= o_fill + FW'(1);
      end
    end
  end

  // Registered output stage; the word and error flag only change on accept,
  // so they hold while the downstream stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_word  <= '0;
      o_err   <= 1'b0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_word  <= dec_word;
      o_err   <= dec_err;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
